// File: rtl/ccg_resp_pkg.sv
// Shared types and helpers for the CCGRCG response compactor: FSM states,
// default MISR constants and the single-step MISR update function.
package ccg_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;
  localparam int unsigned MISR_MAX_W   = 64;

  // One MISR step at an arbitrary width up to MISR_MAX_W; callers zero-extend
  // their operands and keep the low `width` bits of the result.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] din,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  fb;
    mask = (width >= MISR_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    fb   = sig[width-1];
    return ((sig << 1) ^ (fb ? poly : '0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/ccg_popcount.sv
// Combinational population count of a W-bit vector.
module ccg_popcount #(
  parameter int unsigned W  = 29,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/ccg_resp_compactor.sv
// MISR response compactor: folds accepted response vectors into a signature,
// counts beats and compares against an expected signature at end of run.
// Optional ones counter is enabled by defining CCG_RESP_ONES_COUNT_EN.
module ccg_resp_compactor
  import ccg_resp_pkg::*;
#(
  parameter int unsigned         OUT_W = 29,
  parameter int unsigned         SIG_W = 32,
  parameter logic [SIG_W-1:0]    POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0]    SEED  = SIG_W'(DEFAULT_SEED),
  parameter int unsigned         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
`ifdef CCG_RESP_ONES_COUNT_EN
  ,
  output logic [CNT_W+4:0] ones_total
`endif
);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, exp_q, exp_d, sig_step;
  logic [CNT_W-1:0] cnt_q, cnt_d, num_q, num_d, cnt_inc;
  logic             pass_q, pass_d;
  logic             beat, load;
  logic [MISR_MAX_W-1:0] step_ext;

  assign step_ext = misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(POLY),
                              MISR_MAX_W'(in_data), SIG_W);
  assign sig_step = step_ext[SIG_W-1:0];
  assign cnt_inc  = cnt_q + 1'b1;

  // NOTE: every combinationally written variable gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    beat    = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load  = 1'b1;
          sig_d = SEED;
          cnt_d = '0;
          num_d = num_vec;
          exp_d = exp_sig;
          if (num_vec == '0) begin
            state_d = ST_DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          beat  = 1'b1;
          sig_d = sig_step;
          cnt_d = cnt_inc;
          // pass is judged on the signature that includes this final beat
          if (cnt_inc == num_q) begin
            state_d = ST_DONE;
            pass_d  = (sig_step == exp_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

`ifdef CCG_RESP_ONES_COUNT_EN
  localparam int unsigned ONES_W = CNT_W + 5;
  localparam int unsigned POP_W  = $clog2(OUT_W + 1);

  logic [POP_W-1:0]  pop;
  logic [ONES_W:0]   ones_sum;
  logic [ONES_W-1:0] ones_q, ones_d;

  ccg_popcount #(.W(OUT_W), .CW(POP_W)) u_popcount (
    .data_i  (in_data),
    .count_o (pop)
  );

  assign ones_sum = {1'b0, ones_q} + (ONES_W + 1)'(pop);

  always_comb begin
    ones_d = ones_q;
    if (load)      ones_d = '0;
    else if (beat) ones_d = ones_sum[ONES_W] ? '1 : ones_sum[ONES_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) ones_q <= '0;
    else     ones_q <= ones_d;
  end

  assign ones_total = ones_q;
`else
  logic unused_load;
  assign unused_load = load | beat;
`endif

endmodule
